inverse_ctrl: RTL and testbench

Host-facing controller directly upstream of the `inverse` stage. It buffers a 6×6 matrix of 36-bit fixed-point entries written by the host and drives the inverse stage's `en`, `rst` and `count` sequencing for one 229-cycle run. It captures the inverted matrix at the end of the run and serves it back to the host through a registered read port.

---
 rtl/inverse_ctrl_pkg.sv | 19 +
 rtl/inverse_ctrl_if.sv | 28 ++
 rtl/inverse_ctrl_mat_bank.sv | 34 +++
 rtl/inverse_ctrl.sv | 130 +++++++++++++
 tb/tb_inverse_ctrl.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/inverse_ctrl_pkg.sv
// Shared types and default sizing for the inverse-stage controller.
package inverse_ctrl_pkg;

  localparam int unsigned N_DEF          = 6;
  localparam int unsigned WIDTH_DEF      = 36;
  localparam int unsigned RUN_CYCLES_DEF = 229;
  localparam int unsigned ENTRIES        = N_DEF * N_DEF;
  localparam int unsigned AW             = 6;
  localparam int unsigned CW             = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    CAPTURE,
    DONE
  } state_t;

endpackage

// File: rtl/inverse_ctrl_if.sv
// Host-side write/start/read port of the inverse-stage controller.
interface inverse_ctrl_if
  import inverse_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) ();

  logic             wr_en;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic             start;
  logic             busy;
  logic             done;
  logic             wr_err;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data;

  modport master (
    output wr_en, wr_addr, wr_data, start, rd_addr,
    input  busy, done, wr_err, rd_data
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, rd_addr,
    output busy, done, wr_err, rd_data
  );

endinterface

// File: rtl/inverse_ctrl_mat_bank.sv
// Matrix register bank: async clear, single write port, whole-bank parallel load.
module mat_bank #(
  parameter int unsigned ENT   = 36,
  parameter int unsigned WIDTH = 36,
  parameter int unsigned AW    = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic [AW-1:0]        waddr,
  input  logic [WIDTH-1:0]     wdata,
  input  logic                 ld,
  input  logic [ENT*WIDTH-1:0] ld_data,
  output logic [ENT*WIDTH-1:0] q
);

  logic [WIDTH-1:0] mem [ENT];

  // Parallel load wins over the single-entry write port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(ENT); i++) mem[i] <= '0;
    end else if (ld) begin
      for (int i = 0; i < int'(ENT); i++) mem[i] <= ld_data[i*WIDTH +: WIDTH];
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < int'(ENT); g++) begin : g_flat
    assign q[g*WIDTH +: WIDTH] = mem[g];
  end

endmodule

// File: rtl/inverse_ctrl.sv
// Sequences one inverse-stage run over a host-written operand bank and serves the result.
module inverse_ctrl
  import inverse_ctrl_pkg::*;
#(
  parameter int unsigned N          = N_DEF,
  parameter int unsigned WIDTH      = WIDTH_DEF,
  parameter int unsigned RUN_CYCLES = RUN_CYCLES_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  inverse_ctrl_if.slave          host,
  output logic                   inv_en,
  output logic                   inv_rst,
  output logic [CW-1:0]          inv_count,
  output logic [N*N*WIDTH-1:0]   mat_out,
  input  logic [N*N*WIDTH-1:0]   res_in
);

  localparam int unsigned NENT = N * N;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic             busy_q, busy_nx;
  logic             done_q, done_nx;
  logic             err_q, err_nx;
  logic             en_q, en_nx;
  logic             clr_q, clr_nx;
  logic [WIDTH-1:0] rd_q, rd_nx;
  logic             idle_like, wr_ok, res_ld;
  logic [NENT*WIDTH-1:0] res_flat;
  logic [WIDTH-1:0] res_ent [NENT];

  for (genvar g = 0; g < int'(NENT); g++) begin : g_unpack
    assign res_ent[g] = res_flat[g*WIDTH +: WIDTH];
  end

  // Next state, counter, error flag and read mux; outputs follow the next state.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    res_ld    = 1'b0;
    idle_like = (state == IDLE) || (state == DONE);
    wr_ok     = host.wr_en && idle_like && (32'(host.wr_addr) < NENT);
    err_nx    = err_q;
    if (host.start && idle_like) err_nx = 1'b0;
    if (host.wr_en && !wr_ok)    err_nx = 1'b1;

    case (state)
      IDLE:    if (host.start) state_nx = CLEAR;
      DONE:    state_nx = host.start ? CLEAR : IDLE;
      CLEAR: begin
        state_nx = RUN;
        cnt_nx   = '0;
      end
      RUN: begin
        if (cnt == CW'(RUN_CYCLES - 1)) begin
          state_nx = CAPTURE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt + CW'(1);
        end
      end
      CAPTURE: begin
        state_nx = DONE;
        res_ld   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase

    busy_nx = state_nx inside {CLEAR, RUN, CAPTURE};
    done_nx = (state_nx == DONE);
    en_nx   = (state_nx == RUN);
    clr_nx  = (state_nx == CLEAR);
    rd_nx   = (32'(host.rd_addr) < NENT) ? res_ent[host.rd_addr] : '0;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      en_q   <= 1'b0;
      clr_q  <= 1'b0;
      rd_q   <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      busy_q <= busy_nx;
      done_q <= done_nx;
      err_q  <= err_nx;
      en_q   <= en_nx;
      clr_q  <= clr_nx;
      rd_q   <= rd_nx;
    end
  end

  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.wr_err  = err_q;
  assign host.rd_data = rd_q;
  assign inv_en       = en_q;
  assign inv_rst      = clr_q;
  assign inv_count    = cnt;

  mat_bank #(.ENT(NENT), .WIDTH(WIDTH), .AW(AW)) u_op_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (wr_ok),
    .waddr   (host.wr_addr),
    .wdata   (host.wr_data),
    .ld      (1'b0),
    .ld_data ('0),
    .q       (mat_out)
  );

  mat_bank #(.ENT(NENT), .WIDTH(WIDTH), .AW(AW)) u_res_bank (
    .clk     (clk),
    .rst     (rst),
    .we      (1'b0),
    .waddr   ('0),
    .wdata   ('0),
    .ld      (res_ld),
    .ld_data (res_in),
    .q       (res_flat)
  );

endmodule

// File: tb/tb_inverse_ctrl.sv
// Randomised bench for inverse_ctrl against a run-age behavioural model.
module tb_inverse_ctrl;

  localparam int W          = 36;
  localparam int NE         = 36;
  localparam int RC         = 229;
  localparam int J_RUN_LAST = RC + 1;
  localparam int J_CAP      = RC + 2;
  localparam int J_DONE     = RC + 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            inv_en, inv_rst;
  logic [7:0]      inv_count;
  logic [NE*W-1:0] mat_out;
  logic [NE*W-1:0] res_in;
  logic [W-1:0]    res_arr [NE];

  inverse_ctrl_if #(.WIDTH(W)) hif ();

  inverse_ctrl #(.N(6), .WIDTH(W), .RUN_CYCLES(RC)) dut (
    .clk       (clk),
    .rst       (rst),
    .host      (hif),
    .inv_en    (inv_en),
    .inv_rst   (inv_rst),
    .inv_count (inv_count),
    .mat_out   (mat_out),
    .res_in    (res_in)
  );

  always #5 clk = ~clk;

  always_comb begin
    res_in = '0;
    for (int i = 0; i < NE; i++) res_in[i*W +: W] = res_arr[i];
  end

  // Model: m_age = cycles since the accepted start (0 = idle).
  int           m_age;
  logic         m_err;
  logic [W-1:0] m_rd;
  logic [W-1:0] m_op  [NE];
  logic [W-1:0] m_res [NE];
  logic         m_idle, m_wr_ok, m_acc;

  assign m_idle  = (m_age == 0) || (m_age == J_DONE);
  assign m_wr_ok = hif.wr_en && m_idle && (hif.wr_addr < 6'd36);
  assign m_acc   = hif.start && m_idle;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_age <= 0;
      m_err <= 1'b0;
      m_rd  <= '0;
      for (int i = 0; i < NE; i++) begin
        m_op[i]  <= '0;
        m_res[i] <= '0;
      end
    end else begin
      if (m_wr_ok) m_op[hif.wr_addr] <= hif.wr_data;
      if (hif.wr_en && !m_wr_ok) m_err <= 1'b1;
      else if (m_acc)            m_err <= 1'b0;
      if (m_age == J_CAP)
        for (int i = 0; i < NE; i++) m_res[i] <= res_in[i*W +: W];
      m_rd  <= (hif.rd_addr < 6'd36) ? m_res[hif.rd_addr] : '0;
      m_age <= m_acc ? 1 : (m_idle ? 0 : m_age + 1);
    end
  end

  // Event monitor for the hand-computed timing checks.
  int   cyc = 0;
  int   mon_rst_last = -1, mon_rst_total = 0;
  int   mon_en_first = -1, mon_en_last = -1, mon_cnt_max = 0;
  int   mon_done_last = -1, mon_done_total = 0;
  logic mon_en_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (inv_rst) begin
      mon_rst_last  <= cyc;
      mon_rst_total <= mon_rst_total + 1;
    end
    if (inv_en && !mon_en_prev) mon_en_first <= cyc;
    if (inv_en) begin
      mon_en_last <= cyc;
      if (int'(inv_count) > mon_cnt_max) mon_cnt_max <= int'(inv_count);
    end
    mon_en_prev <= inv_en;
    if (hif.done) begin
      mon_done_total <= mon_done_total + 1;
      mon_done_last  <= cyc;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic compare_all();
    int idx;
    idx = 0;
    chk("busy",      64'(hif.busy),   64'(m_age >= 1 && m_age <= J_CAP));
    chk("done",      64'(hif.done),   64'(m_age == J_DONE));
    chk("inv_rst",   64'(inv_rst),    64'(m_age == 1));
    chk("inv_en",    64'(inv_en),     64'(m_age >= 2 && m_age <= J_RUN_LAST));
    chk("inv_count", 64'(inv_count),
        (m_age >= 2 && m_age <= J_RUN_LAST) ? 64'(m_age - 2) : 64'd0);
    chk("wr_err",    64'(hif.wr_err), 64'(m_err));
    chk("rd_data",   64'(hif.rd_data), 64'(m_rd));
    for (int i = NE - 1; i >= 0; i--) if (mat_out[i*W +: W] !== m_op[i]) idx = i;
    chk($sformatf("mat_out[%0d]", idx), 64'(mat_out[idx*W +: W]), 64'(m_op[idx]));
  endtask

  // One cycle: compare away from the edge, then step past the next rising edge.
  task automatic tick();
    @(negedge clk);
    compare_all();
    @(posedge clk);
    #1;
    hif.start = 1'b0;
    hif.wr_en = 1'b0;
  endtask

  task automatic wr(input int a, input logic [W-1:0] d);
    hif.wr_en   = 1'b1;
    hif.wr_addr = 6'(a);
    hif.wr_data = d;
    tick();
  endtask

  function automatic logic [W-1:0] rnd36();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[W-1:0];
  endfunction

  task automatic wait_count(input int c, output bit found);
    found = 1'b0;
    for (int t = 0; t < 300 && !found; t++) begin
      if (inv_en && int'(inv_count) == c) found = 1'b1;
      else tick();
    end
    chk($sformatf("reach_count_%0d", c), 64'(found), 64'd1);
  endtask

  int k, d0, r0;
  bit found;

  initial begin
    hif.wr_en = 1'b0; hif.wr_addr = '0; hif.wr_data = '0;
    hif.start = 1'b0; hif.rd_addr = '0;
    for (int i = 0; i < NE; i++) res_arr[i] = '0;
    repeat (3) tick();
    chk("reset_busy", 64'(hif.busy), 64'd0);
    chk("reset_mat",  64'(mat_out == '0), 64'd1);
    rst = 1'b0;
    tick();

    // Basic run: scaled identity in, entry i = i+1 out.
    for (int i = 0; i < NE; i++) wr(i, (i / 6 == i % 6) ? 36'h10000 : 36'h0);
    for (int i = 0; i < NE; i++) res_arr[i] = 36'(i + 1);
    d0 = mon_done_total; r0 = mon_rst_total;
    hif.start = 1'b1; tick(); k = cyc;
    repeat (235) tick();
    chk("basic_rst_cycle",  64'(mon_rst_last),  64'(k));
    chk("basic_rst_once",   64'(mon_rst_total - r0), 64'd1);
    chk("basic_en_first",   64'(mon_en_first),  64'(k + 1));
    chk("basic_en_last",    64'(mon_en_last),   64'(k + 229));
    chk("basic_count_max",  64'(mon_cnt_max),   64'd228);
    chk("basic_done_cycle", 64'(mon_done_last), 64'(k + 231));
    chk("basic_done_once",  64'(mon_done_total - d0), 64'd1);
    hif.rd_addr = 6'd35; tick();
    chk("basic_rd35", 64'(hif.rd_data), 64'd36);

    // Write protection while busy.
    for (int i = 0; i < NE; i++) res_arr[i] = rnd36();
    hif.start = 1'b1; tick();
    repeat (10) tick();
    wr(5, 36'hABC);
    chk("prot_entry5", 64'(mat_out[5*W +: W]), 64'd0);
    chk("prot_err",    64'(hif.wr_err), 64'd1);
    repeat (230) tick();
    chk("prot_err_held", 64'(hif.wr_err), 64'd1);
    hif.start = 1'b1; tick();
    chk("prot_err_cleared", 64'(hif.wr_err), 64'd0);
    repeat (235) tick();

    // Out-of-range write and read.
    wr(36, 36'h123);
    chk("oor_err", 64'(hif.wr_err), 64'd1);
    hif.rd_addr = 6'd40; tick();
    chk("oor_rd", 64'(hif.rd_data), 64'd0);

    // Start while busy is ignored.
    d0 = mon_done_total;
    hif.start = 1'b1; tick(); k = cyc;
    wait_count(100, found);
    hif.start = 1'b1; tick();
    repeat (240) tick();
    chk("busy_start_done_once",  64'(mon_done_total - d0), 64'd1);
    chk("busy_start_done_cycle", 64'(mon_done_last), 64'(k + 231));

    // Reset mid-run.
    hif.start = 1'b1; tick();
    wait_count(50, found);
    d0 = mon_done_total;
    rst = 1'b1;
    #2;
    chk("mid_rst_en",    64'(inv_en),    64'd0);
    chk("mid_rst_count", 64'(inv_count), 64'd0);
    chk("mid_rst_busy",  64'(hif.busy),  64'd0);
    chk("mid_rst_mat",   64'(mat_out == '0), 64'd1);
    tick(); tick();
    rst = 1'b0;
    hif.rd_addr = 6'd35;
    repeat (300) tick();
    chk("mid_rst_no_done", 64'(mon_done_total - d0), 64'd0);
    chk("mid_rst_res_zero", 64'(hif.rd_data), 64'd0);
    d0 = mon_done_total;
    hif.start = 1'b1; tick(); k = cyc;
    repeat (235) tick();
    chk("fresh_done_cycle", 64'(mon_done_last), 64'(k + 231));
    chk("fresh_done_once",  64'(mon_done_total - d0), 64'd1);

    // Back-to-back runs.
    for (int i = 0; i < NE; i++) res_arr[i] = 36'(500 + i);
    hif.start = 1'b1; tick();
    repeat (231) tick();
    chk("b2b_in_done", 64'(hif.done), 64'd1);
    for (int i = 0; i < NE; i++) res_arr[i] = 36'(1000 + i);
    hif.start = 1'b1; tick();
    chk("b2b_clear_next", 64'(inv_rst), 64'd1);
    repeat (235) tick();
    hif.rd_addr = 6'd7; tick();
    chk("b2b_overwrite", 64'(hif.rd_data), 64'd1007);

    // Randomised traffic.
    for (int t = 0; t < 2500; t++) begin
      hif.wr_en   = ($urandom_range(0, 2) == 0);
      hif.wr_addr = 6'($urandom_range(0, 63));
      hif.wr_data = rnd36();
      hif.start   = ($urandom_range(0, 199) == 0);
      hif.rd_addr = 6'($urandom_range(0, 63));
      for (int i = 0; i < NE; i++) res_arr[i] = rnd36();
      tick();
    end
    repeat (240) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
